// File: rtl/gate_model_test_sequencer.sv
// BIST sequencer for a 22-input / 10-output GateModel netlist.
// A 22-bit LFSR drives stimulus, and a 10-bit MISR folds in the responses.
module gate_model_test_sequencer #(
  parameter logic [21:0] SEED          = 22'h000001,
  parameter int          NUM_PATTERNS  = 1024,
  parameter int          SETTLE_CYCLES = 2,
  parameter int          CNT_W         = 16,
  parameter logic [9:0]  EXP_SIG       = 10'h000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [9:0]       dut_out,
  output logic [21:0]      dut_in,
  output logic             busy,
  output logic             done,
  output logic [9:0]       signature,
  output logic             pass,
  output logic [CNT_W-1:0] pattern_idx
);

  localparam logic [21:0]      SEED_EFF = (SEED == 22'h000000) ? 22'h000001 : SEED;
  localparam int               SC_W     = $clog2(SETTLE_CYCLES + 2);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NUM_PATTERNS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APPLY   = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [21:0]      lfsr_r;
  logic [9:0]       misr_r;
  logic [21:0]      din_r;
  logic [CNT_W-1:0] idx_r;
  logic [SC_W-1:0]  settle_cnt_r;
  logic             busy_r, done_r, pass_r;
  logic [9:0]       misr_nxt_s;
  logic             last_s;

  // x^10 + x^3 + 1 signature register step
  function automatic logic [9:0] misr_step(input logic [9:0] cur, input logic [9:0] resp);
    return ({cur[8:0], 1'b0} ^ (cur[9] ? 10'h009 : 10'h000)) ^ resp;
  endfunction

  // x^22 + x^21 + 1 stimulus generator step
  function automatic logic [21:0] lfsr_step(input logic [21:0] cur);
    return {cur[20:0], cur[21] ^ cur[20]};
  endfunction

  // Next-state selection; abort pre-empts every non-idle state
  always_comb begin
    state_s    = state_r;
    misr_nxt_s = misr_step(misr_r, dut_out);
    last_s     = (idx_r == IDX_LAST);
    case (state_r)
      IDLE:    if (start) state_s = APPLY; else state_s = IDLE;
      APPLY:   if (abort) state_s = IDLE;
               else if (SETTLE_CYCLES == 0) state_s = CAPTURE;
               else state_s = SETTLE;
      SETTLE:  if (abort) state_s = IDLE;
               else if (settle_cnt_r == SC_LAST) state_s = CAPTURE;
               else state_s = SETTLE;
      CAPTURE: if (abort) state_s = IDLE;
               else if (last_s) state_s = DONE;
               else state_s = APPLY;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == APPLY) || (state_s == SETTLE) || (state_s == CAPTURE);
      done_r  <= (state_s == DONE);
    end
  end

  // Stimulus, response compaction and pattern bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r       <= SEED_EFF;
      misr_r       <= 10'h000;
      din_r        <= 22'h000000;
      idx_r        <= '0;
      settle_cnt_r <= '0;
      pass_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            misr_r <= 10'h000;
            pass_r <= 1'b0;
            idx_r  <= '0;
            lfsr_r <= SEED_EFF;
          end
        end
        APPLY: begin
          settle_cnt_r <= '0;
          if (!abort) din_r <= lfsr_r;
        end
        SETTLE: settle_cnt_r <= settle_cnt_r + SC_W'(1);
        CAPTURE: begin
          if (!abort) begin
            misr_r <= misr_nxt_s;
            lfsr_r <= lfsr_step(lfsr_r);
            // pass is resolved on entry to DONE so it is already valid in the done cycle
            if (last_s) pass_r <= (misr_nxt_s == EXP_SIG);
            else idx_r <= idx_r + CNT_W'(1);
          end
        end
        DONE: ;
        default: ;
      endcase
      if (abort && (state_r != IDLE)) pass_r <= 1'b0;
    end
  end

  assign dut_in      = din_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign signature   = misr_r;
  assign pass        = pass_r;
  assign pattern_idx = idx_r;

endmodule

// File: tb/tb_gate_model_test_sequencer.sv
// Bench for gate_model_test_sequencer: directed literal cases on small configurations plus
// a randomized start/abort run compared every cycle against a cycle-indexed run model.
module tb_gate_model_test_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_d = 1'b0;
  logic no_abort = 1'b0;
  logic start_e = 1'b0;
  logic abort_e = 1'b0;
  int   nchecks = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  // Directed instances: A (N=3,S=0), B (N=2,S=0,EXP=0), C (N=1,S=2,all-ones), D (A with SEED=0)
  logic [21:0] din_a, din_b, din_c, din_d, din_e;
  logic [9:0]  out_a, out_b, out_c, out_d, out_e;
  logic [9:0]  sig_a, sig_b, sig_c, sig_d, sig_e;
  logic        busy_a, busy_b, busy_c, busy_d, busy_e;
  logic        done_a, done_b, done_c, done_d, done_e;
  logic        pass_a, pass_b, pass_c, pass_d, pass_e;
  logic [15:0] idx_a, idx_b, idx_c, idx_d;
  logic [7:0]  idx_e;

  assign out_a = din_a[9:0];
  assign out_b = din_b[9:0];
  assign out_c = 10'h3FF;
  assign out_d = din_d[9:0];
  assign out_e = din_e[9:0] ^ din_e[21:12];

  gate_model_test_sequencer #(.SEED(22'h000001), .NUM_PATTERNS(3), .SETTLE_CYCLES(0), .CNT_W(16), .EXP_SIG(10'h004))
    u_a (.clk(clk), .rst(rst), .start(start_d), .abort(no_abort), .dut_out(out_a), .dut_in(din_a),
         .busy(busy_a), .done(done_a), .signature(sig_a), .pass(pass_a), .pattern_idx(idx_a));
  gate_model_test_sequencer #(.SEED(22'h000001), .NUM_PATTERNS(2), .SETTLE_CYCLES(0), .CNT_W(16), .EXP_SIG(10'h000))
    u_b (.clk(clk), .rst(rst), .start(start_d), .abort(no_abort), .dut_out(out_b), .dut_in(din_b),
         .busy(busy_b), .done(done_b), .signature(sig_b), .pass(pass_b), .pattern_idx(idx_b));
  gate_model_test_sequencer #(.SEED(22'h000001), .NUM_PATTERNS(1), .SETTLE_CYCLES(2), .CNT_W(16), .EXP_SIG(10'h3FF))
    u_c (.clk(clk), .rst(rst), .start(start_d), .abort(no_abort), .dut_out(out_c), .dut_in(din_c),
         .busy(busy_c), .done(done_c), .signature(sig_c), .pass(pass_c), .pattern_idx(idx_c));
  gate_model_test_sequencer #(.SEED(22'h000000), .NUM_PATTERNS(3), .SETTLE_CYCLES(0), .CNT_W(16), .EXP_SIG(10'h004))
    u_d (.clk(clk), .rst(rst), .start(start_d), .abort(no_abort), .dut_out(out_d), .dut_in(din_d),
         .busy(busy_d), .done(done_d), .signature(sig_d), .pass(pass_d), .pattern_idx(idx_d));

  localparam int          EN    = 6;
  localparam int          ES    = 2;
  localparam int          EL    = EN * (ES + 2);
  localparam logic [21:0] ESEED = 22'h2A5C3;
  localparam logic [9:0]  EEXP  = 10'h155;

  gate_model_test_sequencer #(.SEED(ESEED), .NUM_PATTERNS(EN), .SETTLE_CYCLES(ES), .CNT_W(8), .EXP_SIG(EEXP))
    u_e (.clk(clk), .rst(rst), .start(start_e), .abort(abort_e), .dut_out(out_e), .dut_in(din_e),
         .busy(busy_e), .done(done_e), .signature(sig_e), .pass(pass_e), .pattern_idx(idx_e));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] misr_f(input logic [9:0] s, input logic [9:0] r);
    logic [10:0] w;
    w = {s, 1'b0};
    if (w[10]) w = w ^ 11'h409;
    return w[9:0] ^ r;
  endfunction

  function automatic logic [21:0] lfsr_f(input logic [21:0] l);
    return {l[20:0], l[21] ^ l[20]};
  endfunction

  function automatic logic [9:0] full_stub_sig(input logic [21:0] seed, input int n);
    logic [21:0] l;
    logic [9:0]  s;
    l = (seed == 22'h0) ? 22'h1 : seed;
    s = 10'h0;
    for (int i = 0; i < n; i++) begin
      s = misr_f(s, l[9:0]);
      l = lfsr_f(l);
    end
    return s;
  endfunction

  // Run model: t counts cycles since the start edge; cycle EL+1 is the done cycle
  typedef struct {
    bit          run;
    int          t;
    logic [9:0]  sig;
    bit          pass;
    int          idx;
    logic [21:0] din;
    logic [21:0] lfsr;
  } mstate_t;

  function automatic mstate_t mreset();
    mstate_t n;
    n.run = 1'b0; n.t = 0; n.sig = 10'h0; n.pass = 1'b0; n.idx = 0; n.din = 22'h0; n.lfsr = ESEED;
    return n;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input logic st, input logic ab);
    mstate_t n;
    int o, p;
    n = s;
    if (!s.run) begin
      if (st) begin
        n.run = 1'b1; n.t = 1; n.sig = 10'h0; n.pass = 1'b0; n.idx = 0; n.lfsr = ESEED;
      end
    end else if (ab) begin
      n.run = 1'b0; n.pass = 1'b0;
    end else if (s.t == EL + 1) begin
      n.run = 1'b0;
    end else begin
      o = (s.t - 1) % (ES + 2);
      p = (s.t - 1) / (ES + 2);
      if (o == 0) n.din = s.lfsr;
      if (o == ES + 1) begin
        n.sig  = misr_f(s.sig, s.din[9:0] ^ s.din[21:12]);
        n.lfsr = lfsr_f(s.lfsr);
        if (p == EN - 1) n.pass = (n.sig == EEXP);
        else n.idx = p + 1;
      end
      n.t = s.t + 1;
    end
    return n;
  endfunction

  mstate_t m;
  always @(posedge clk or posedge rst) begin
    if (rst) m <= mreset();
    else m <= mstep(m, start_e, abort_e);
  end

  logic [9:0] ref_sig;
  bit         have_ref = 1'b0;

  always @(negedge clk) begin
    chk("e_busy", 32'(busy_e), 32'(m.run && (m.t <= EL)));
    chk("e_done", 32'(done_e), 32'(m.run && (m.t == EL + 1)));
    chk("e_dut_in", 32'(din_e), 32'(m.din));
    chk("e_signature", 32'(sig_e), 32'(m.sig));
    chk("e_pass", 32'(pass_e), 32'(m.pass));
    chk("e_pattern_idx", 32'(idx_e), 32'(m.idx));
    if (done_e) begin
      if (have_ref) chk("e_rerun_sig", 32'(sig_e), 32'(ref_sig));
      else begin
        ref_sig  = sig_e;
        have_ref = 1'b1;
      end
    end
  end

  int done_at_a, done_at_b, done_at_c, done_at_d;
  int ndone_a, ndone_b, ndone_c, ndone_d;

  initial begin
    done_at_a = 0; done_at_b = 0; done_at_c = 0; done_at_d = 0;
    ndone_a = 0; ndone_b = 0; ndone_c = 0; ndone_d = 0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_sig", 32'(sig_a), 32'h0);
    chk("rst_dut_in", 32'(din_a), 32'h0);
    chk("rst_flags", 32'({busy_a, done_a, pass_a}), 32'h0);
    chk("rst_idx", 32'(idx_a), 32'h0);
    #1 rst = 1'b0;

    chk("model_pin_n3", 32'(full_stub_sig(22'h1, 3)), 32'h004);
    chk("model_pin_n2", 32'(full_stub_sig(22'h1, 2)), 32'h000);

    // Directed run on A..D; an extra start pulse in cycle 3 must be ignored
    @(negedge clk);
    #1 start_d = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done_a) begin done_at_a = k; ndone_a++; end
      if (done_b) begin done_at_b = k; ndone_b++; end
      if (done_c) begin done_at_c = k; ndone_c++; end
      if (done_d) begin done_at_d = k; ndone_d++; end
      if (k == 2) begin chk("a_din_p0", 32'(din_a), 32'h1); chk("d_din_p0", 32'(din_d), 32'h1); end
      if (k == 4) begin chk("a_din_p1", 32'(din_a), 32'h2); chk("d_din_p1", 32'(din_d), 32'h2); end
      if (k == 6) begin chk("a_din_p2", 32'(din_a), 32'h4); chk("d_din_p2", 32'(din_d), 32'h4); end
      chk("c_busy", 32'(busy_c), 32'(k <= 4));
      if (k >= 2 && k <= 4) chk("c_din_stable", 32'(din_c), 32'h1);
      #1 start_d = (k == 3);
    end
    chk("a_done_cycle", 32'(done_at_a), 32'd7);
    chk("a_done_count", 32'(ndone_a), 32'd1);
    chk("a_sig", 32'(sig_a), 32'h004);
    chk("a_pass", 32'(pass_a), 32'h1);
    chk("b_done_cycle", 32'(done_at_b), 32'd5);
    chk("b_done_count", 32'(ndone_b), 32'd1);
    chk("b_sig", 32'(sig_b), 32'h000);
    chk("b_pass", 32'(pass_b), 32'h1);
    chk("c_done_cycle", 32'(done_at_c), 32'd5);
    chk("c_sig", 32'(sig_c), 32'h3FF);
    chk("c_pass", 32'(pass_c), 32'h1);
    chk("d_done_cycle", 32'(done_at_d), 32'd7);
    chk("d_sig", 32'(sig_d), 32'h004);

    // E: abort during the second pattern's settle window, then a full run
    @(negedge clk); #1 start_e = 1'b1;
    @(negedge clk); #1 start_e = 1'b0;
    repeat (5) @(negedge clk);
    #1 abort_e = 1'b1;
    @(negedge clk); #1 abort_e = 1'b0;
    chk("e_abort_idle", 32'(busy_e), 32'h0);
    @(negedge clk); #1 start_e = 1'b1;
    @(negedge clk); #1 start_e = 1'b0;
    repeat (EL + 4) @(negedge clk);

    // E: asynchronous reset in the middle of a run
    #1 start_e = 1'b1;
    @(negedge clk); #1 start_e = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_outs", 32'({busy_e, done_e, pass_e, idx_e, sig_e}), 32'h0);
    chk("async_rst_din", 32'(din_e), 32'h0);
    @(negedge clk); #1 rst = 1'b0;

    // E: randomized start/abort traffic
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      #1;
      start_e = ($urandom_range(0, 3) == 0);
      abort_e = ($urandom_range(0, 39) == 0);
    end
    start_e = 1'b0;
    abort_e = 1'b0;
    repeat (EL + 4) @(negedge clk);
    chk("e_saw_full_run", 32'(have_ref), 32'h1);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
